// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, clamp bounds and types for the PE requantizer datapath.
package pe_pkg;
   localparam int ACC_W   = 24;
   localparam int SCALE_W = 16;
   localparam int SHIFT_W = 5;
   localparam int OUT_W   = 8;
   localparam int PROD_W  = ACC_W + SCALE_W + 1;
   localparam int QMAX_U  = 2**OUT_W - 1;
   localparam int QMAX_S  = 2**(OUT_W-1) - 1;
   localparam int QMIN_S  = -(2**(OUT_W-1));
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic [OUT_W-1:0] q8_t;
   typedef struct packed {
      logic [SCALE_W-1:0] scale;
      logic [SHIFT_W-1:0] shift;
      logic               relu;
   } requant_cfg_t;
endpackage

// File: rtl/pe_round_clamp.sv
// pe_round_clamp: combinational round-half-up arithmetic shift, then ReLU clamp or signed saturate.
module pe_round_clamp
   import pe_pkg::*;
(
   input  logic [PROD_W-1:0]  prod,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               relu,
   output logic [OUT_W-1:0]   q,
   output logic               sat
);
   localparam logic signed [PROD_W:0] HI_U = (PROD_W+1)'(QMAX_U);
   localparam logic signed [PROD_W:0] HI_S = (PROD_W+1)'(QMAX_S);
   localparam logic signed [PROD_W:0] LO_S = (PROD_W+1)'(QMIN_S);
   logic signed [PROD_W:0] rnd, r;
   logic over, under;
   // One guard bit above the product keeps the rounding add from overflowing.
   always_comb begin
      rnd   = (shift == '0) ? '0 : (PROD_W+1)'(1) << (shift - 1'b1);
      r     = ($signed({prod[PROD_W-1], prod}) + rnd) >>> shift;
      over  = relu ? (r > HI_U) : (r > HI_S);
      under = !relu && (r < LO_S);
      sat   = over || under;
      q     = over ? (relu ? q8_t'(QMAX_U) : q8_t'(QMAX_S)) :
              under ? q8_t'(QMIN_S) :
              (relu && r[PROD_W]) ? '0 : r[OUT_W-1:0];
   end
endmodule

// File: rtl/pe_requant.sv
// pe_requant: two-stage scale/round/clamp requantizer with valid/ready on both sides.
// Saturation counter is built only when PE_REQUANT_SATCNT_EN is defined.
module pe_requant
   import pe_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [SCALE_W-1:0] cfg_scale,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic               cfg_relu,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ACC_W-1:0]   in_acc,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic               out_last,
   input  logic               sat_clr,
   output logic [15:0]        sat_count
);
   requant_cfg_t cfg;
   logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_relu_q, s1_relu_d;
   logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
   logic [PROD_W-1:0] s1_prod_q, s1_prod_d;
   logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic [OUT_W-1:0] s2_data_q, s2_data_d, q;
   logic in_fire, s2_load, sat;

   assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;

   always_comb begin
      cfg        = '{scale: cfg_scale, shift: cfg_shift, relu: cfg_relu};
      in_fire    = in_valid && in_ready;
      s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
      s1_valid_d = in_fire || (s1_valid_q && !s2_load);
      s1_prod_d  = in_fire ? PROD_W'($signed(in_acc)) * PROD_W'($signed({1'b0, cfg.scale})) : s1_prod_q;
      s1_shift_d = in_fire ? cfg.shift : s1_shift_q;
      s1_relu_d  = in_fire ? cfg.relu : s1_relu_q;
      s1_last_d  = in_fire ? in_last : s1_last_q;
      s2_valid_d = s2_load || (s2_valid_q && !out_ready);
      s2_data_d  = s2_load ? q : s2_data_q;
      s2_last_d  = s2_load ? s1_last_q : s2_last_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_shift_q <= '0;
         s1_relu_q  <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_last_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_prod_q  <= s1_prod_d;
         s1_shift_q <= s1_shift_d;
         s1_relu_q  <= s1_relu_d;
         s1_last_q  <= s1_last_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_last_q  <= s2_last_d;
      end
   end

   pe_round_clamp u_round_clamp (
      .prod  (s1_prod_q),
      .shift (s1_shift_q),
      .relu  (s1_relu_q),
      .q     (q),
      .sat   (sat)
   );

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_last  = s2_last_q;

`ifdef PE_REQUANT_SATCNT_EN
   logic [15:0] sat_count_q, sat_count_d;
   // Clear beats a simultaneous event; the count sticks at all-ones.
   always_comb sat_count_d = sat_clr ? '0 :
                             (s2_load && sat && sat_count_q != 16'hFFFF) ? sat_count_q + 1'b1 : sat_count_q;
   always_ff @(posedge clk) sat_count_q <= !reset ? '0 : sat_count_d;
   assign sat_count = sat_count_q;
`else
   logic sat_unused;
   assign sat_unused = sat_clr ^ sat;
   assign sat_count  = '0;
`endif
endmodule
